// File: rtl/uds_pair_feeder_if.sv
// Row stream into the feeder plus the row/control bus it drives toward the UDS engine.
// The master side is the feeder itself; slave is whatever sits on the other end.
interface uds_pair_feeder_if #(
   parameter int A  = 64,
   parameter int DW = 32
) ();
   logic [A*DW-1:0] in_data;
   logic            in_valid;
   logic            in_ready;
   logic [A*DW-1:0] idata;
   logic            idata_valid;
   logic            active;
   logic [1:0]      scale_factor;
   logic [1:0]      function_mode;

   modport master (
      input  in_data, in_valid,
      output in_ready, idata, idata_valid, active, scale_factor, function_mode
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, idata, idata_valid, active, scale_factor, function_mode
   );
endinterface

// File: rtl/uds_pair_feeder.sv
// Buffers upstream rows in pairs and replays each pair back-to-back (active=0 then 1) plus a gap cycle.
// Two cycles from second row accepted to first row out; upstream only sees in_ready in LOAD0/LOAD1.
module uds_pair_feeder #(
   parameter int A  = 64,
   parameter int DW = 32,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    cfg_scale,
   input  logic [1:0]    cfg_mode,
   input  logic [PW-1:0] cfg_pairs,
   uds_pair_feeder_if.master bus,
   output logic          busy,
   output logic          done
);
   localparam int W = A*DW;

   typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, SEND0, SEND1, GAP, FIN} state_t;

   state_t        state;
   logic [W-1:0]  buf0;
   logic [W-1:0]  buf1;
   logic [PW-1:0] pair_cnt;
   logic [PW-1:0] pair_tgt;

   assign bus.in_ready = (state == LOAD0) || (state == LOAD1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         buf0              <= '0;
         buf1              <= '0;
         pair_cnt          <= '0;
         pair_tgt          <= '0;
         bus.idata         <= '0;
         bus.idata_valid   <= 1'b0;
         bus.active        <= 1'b0;
         bus.scale_factor  <= 2'd0;
         bus.function_mode <= 2'd0;
         busy              <= 1'b0;
         done              <= 1'b0;
      end else begin
         bus.idata_valid <= 1'b0;
         bus.active      <= 1'b0;
         done            <= 1'b0;
         case (state)
            IDLE: begin
               // scale/mode registers double as the per-run latch and hold after the run
               if (start) begin
                  pair_tgt          <= cfg_pairs;
                  pair_cnt          <= '0;
                  bus.scale_factor  <= cfg_scale;
                  bus.function_mode <= cfg_mode;
                  busy              <= 1'b1;
                  state             <= (cfg_pairs == '0) ? FIN : LOAD0;
               end
            end
            LOAD0: begin
               if (bus.in_valid) begin
                  buf0  <= bus.in_data;
                  state <= LOAD1;
               end
            end
            LOAD1: begin
               if (bus.in_valid) begin
                  buf1  <= bus.in_data;
                  state <= SEND0;
               end
            end
            SEND0: begin
               bus.idata       <= buf0;
               bus.idata_valid <= 1'b1;
               state           <= SEND1;
            end
            SEND1: begin
               bus.idata       <= buf1;
               bus.idata_valid <= 1'b1;
               bus.active      <= 1'b1;
               pair_cnt        <= pair_cnt + PW'(1);
               state           <= GAP;
            end
            GAP: begin
               state <= (pair_cnt < pair_tgt) ? LOAD0 : FIN;
            end
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uds_pair_feeder.sv
// Bench for uds_pair_feeder: table of runs plus randomized runs against a pair-scoreboard model.
module tb_uds_pair_feeder;
   localparam int A  = 64;
   localparam int DW = 32;
   localparam int PW = 8;
   localparam int W  = A*DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    cfg_scale = 2'd0;
   logic [1:0]    cfg_mode = 2'd0;
   logic [PW-1:0] cfg_pairs = '0;
   logic          busy;
   logic          done;

   uds_pair_feeder_if #(.A(A), .DW(DW)) bus ();

   uds_pair_feeder #(.A(A), .DW(DW), .PW(PW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cfg_scale (cfg_scale),
      .cfg_mode  (cfg_mode),
      .cfg_pairs (cfg_pairs),
      .bus       (bus),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pairs;
      int scale;
      int mode;
      int hole;
      int pct;
      bit mid;
      int lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] d;
      bit           act;
      int           at;
   } ev_t;

   int   n_chk = 0;
   int   n_pass = 0;
   vec_t tbl[6];
   ev_t  evq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got %0h want %0h", nm, act, exp);
   endtask

   task automatic chk_row(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else begin
         int l = 0;
         for (int k = A-1; k >= 0; k--)
            if (act[k*DW +: DW] !== exp[k*DW +: DW]) l = k;
         $display("FAIL %s lane%0d got %h want %h", nm, l, act[l*DW +: DW], exp[l*DW +: DW]);
      end
   endtask

   function automatic logic [W-1:0] mk_row(input int n);
      logic [W-1:0] r;
      for (int k = 0; k < A; k++) r[k*DW +: DW] = DW'(n*256 + k);
      return r;
   endfunction

   // Model: every accepted second row of a pair schedules both rows 1 and 2 edges later.
   task automatic run(input vec_t v);
      int   nacc, ndone, nvalid, hole_left, lat_seen, budget;
      bit   acc;
      ev_t  ev;
      evq.delete();
      nacc = 0; ndone = 0; nvalid = 0; hole_left = 0; lat_seen = -1;
      budget = 40 + v.pairs * ((v.pct > 0) ? 40 : 6) + v.hole;
      for (int e = 0; e < budget; e++) begin
         @(negedge clk);
         if (e == 0) begin
            start = 1'b1;
            cfg_scale = 2'(v.scale);
            cfg_mode = 2'(v.mode);
            cfg_pairs = PW'(v.pairs);
         end else begin
            start = v.mid && (e == 4);
            cfg_scale = 2'(~v.scale);
            cfg_mode = 2'(~v.mode);
            cfg_pairs = PW'(v.pairs + 1);
         end
         if (hole_left > 0) begin
            bus.in_valid = 1'b0;
            hole_left--;
         end else begin
            bus.in_valid = ($urandom_range(99) >= v.pct);
         end
         bus.in_data = mk_row(nacc);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            if (nacc % 2 == 1) begin
               evq.push_back('{d: mk_row(nacc-1), act: 1'b0, at: e+1});
               evq.push_back('{d: mk_row(nacc),   act: 1'b1, at: e+2});
            end
            nacc++;
            if (nacc == 1 && v.hole > 0) hole_left = v.hole;
         end
         if (e == 0) chk("busy_after_start", busy, 1);
         if (bus.idata_valid || (evq.size() > 0 && evq[0].at == e)) begin
            if (evq.size() > 0 && evq[0].at == e) begin
               ev = evq.pop_front();
               chk("idata_valid", bus.idata_valid, 1);
               chk_row("idata", bus.idata, ev.d);
               chk("active", bus.active, ev.act);
            end else begin
               chk("spurious_valid", bus.idata_valid, 0);
            end
            chk("in_ready_while_sending", bus.in_ready, 0);
            chk("scale_factor", bus.scale_factor, v.scale);
            chk("function_mode", bus.function_mode, v.mode);
            if (bus.idata_valid) nvalid++;
         end
         if (done) begin
            ndone++;
            if (lat_seen < 0) lat_seen = e + 1;
            chk("busy_at_done", busy, 0);
         end
         if (lat_seen >= 0 && e >= lat_seen + 3) break;
      end
      start = 1'b0;
      chk("done_seen", (lat_seen >= 0), 1);
      if (v.lat >= 0) chk("done_latency", lat_seen, v.lat);
      chk("done_count", ndone, 1);
      chk("rows_accepted", nacc, 2*v.pairs);
      chk("valid_rows", nvalid, 2*v.pairs);
      chk("rows_pending", evq.size(), 0);
      chk("scale_held", bus.scale_factor, v.scale);
      chk("mode_held", bus.function_mode, v.mode);
      chk("busy_after_run", busy, 0);
   endtask

   // Reset asserted while the second pair's row1 is being sent must clear everything at once.
   task automatic reset_mid();
      bit hit;
      int seen0;
      hit = 1'b0;
      seen0 = 0;
      @(negedge clk);
      start = 1'b1; cfg_pairs = PW'(2); cfg_scale = 2'd3; cfg_mode = 2'd3;
      bus.in_valid = 1'b1;
      bus.in_data = mk_row(7);
      for (int e = 0; e < 40 && !hit; e++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (bus.idata_valid && !bus.active) begin
            seen0++;
            if (seen0 == 2) hit = 1'b1;
         end
      end
      chk("reached_pair1_send1", hit, 1);
      #1 rst_n = 1'b0;
      #1;
      chk_row("rst_idata", bus.idata, '0);
      chk("rst_idata_valid", bus.idata_valid, 0);
      chk("rst_active", bus.active, 0);
      chk("rst_scale", bus.scale_factor, 0);
      chk("rst_mode", bus.function_mode, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk);
         #1;
         chk("post_reset_quiet", {bus.idata_valid, busy, done, bus.in_ready}, 0);
      end
   endtask

   initial begin
      vec_t r;
      tbl[0] = '{pairs: 3,   scale: 0, mode: 0, hole: 0, pct: 0, mid: 1'b0, lat: 17};
      tbl[1] = '{pairs: 3,   scale: 0, mode: 0, hole: 3, pct: 0, mid: 1'b0, lat: 20};
      tbl[2] = '{pairs: 0,   scale: 3, mode: 2, hole: 0, pct: 0, mid: 1'b0, lat: 2};
      tbl[3] = '{pairs: 2,   scale: 2, mode: 1, hole: 0, pct: 0, mid: 1'b1, lat: 12};
      tbl[4] = '{pairs: 255, scale: 1, mode: 3, hole: 0, pct: 0, mid: 1'b0, lat: 1277};
      tbl[5] = '{pairs: 1,   scale: 1, mode: 2, hole: 0, pct: 0, mid: 1'b0, lat: 7};

      bus.in_data = '0;
      bus.in_valid = 1'b0;
      #3;
      chk_row("reset_idata", bus.idata, '0);
      chk("reset_idata_valid", bus.idata_valid, 0);
      chk("reset_active", bus.active, 0);
      chk("reset_scale", bus.scale_factor, 0);
      chk("reset_mode", bus.function_mode, 0);
      chk("reset_in_ready", bus.in_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 6; i++) run(tbl[i]);

      for (int i = 0; i < 6; i++) begin
         r.pairs = int'($urandom_range(1, 6));
         r.scale = int'($urandom_range(0, 3));
         r.mode  = int'($urandom_range(0, 3));
         r.hole  = 0;
         r.pct   = int'($urandom_range(10, 60));
         r.mid   = 1'($urandom_range(0, 1));
         r.lat   = -1;
         run(r);
      end

      reset_mid();
      run(tbl[5]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uds_pair_feeder.md
Name: uds_pair_feeder

Overview:
- Transmit-side front end for the UDS upsample/downsample engine.
- Accepts A-lane rows from an upstream buffer over a valid/ready handshake and stores them as row pairs.
- Replays each pair on the UDS input protocol: row0 with active=0, row1 with active=1, then one idle gap cycle.
- Latches scale_factor/function_mode per run and holds them stable for the run; flags completion after a programmed number of pairs.

Parameters:
- A, 64, lanes per row.
- DW, 32, bits per lane.
- PW, 8, width of the pair counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- cfg_scale  in  2  scale factor, sampled on accepted start.
- cfg_mode  in  2  function mode, sampled on accepted start.
- cfg_pairs  in  PW  number of row pairs in the run, sampled on accepted start.
- in_data  in  A*DW  upstream row.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  feeder can accept a row this cycle.
- idata  out  A*DW  row to UDS.
- idata_valid  out  1  idata valid to UDS.
- active  out  1  high on the second row of a pair.
- scale_factor  out  2  to UDS.
- function_mode  out  2  to UDS.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; idata=0, idata_valid=0, active=0, scale_factor=0, function_mode=0, in_ready=0, busy=0, done=0; pair counter=0; both row buffers cleared.
- Reset mid-run aborts immediately; a partial pair is discarded and nothing further is emitted.
- All outputs are registered except in_ready, which is decoded from the state.
- States:
  - IDLE: in_ready=0. On start: latch cfg_*, drive scale_factor/function_mode from the latched values next cycle, set busy. Go to LOAD0, or to FIN if cfg_pairs=0.
  - LOAD0: in_ready=1. On in_valid: store buf0=in_data, go to LOAD1.
  - LOAD1: in_ready=1. On in_valid: store buf1=in_data, go to SEND0.
  - SEND0: registered outputs next edge: idata=buf0, idata_valid=1, active=0. Go to SEND1.
  - SEND1: idata=buf1, idata_valid=1, active=1; increment pair counter. Go to GAP.
  - GAP: idata_valid=0, active=0; idata holds its last value. Go to LOAD0 if counter<cfg_pairs, else FIN.
  - FIN: done=1 for exactly one cycle, busy=0 on the same edge. Go to IDLE.
- Within a pair, SEND0 and SEND1 are always back-to-back cycles regardless of upstream stalls.
- Every pair is followed by at least one idle (GAP) cycle.
- Upstream stalls (in_valid=0) only lengthen LOAD0/LOAD1. in_ready=0 in SEND0, SEND1, GAP, FIN and IDLE.
- A row is transferred only when in_valid & in_ready; rows offered while in_ready=0 are not consumed.
- start while busy is ignored; cfg inputs are not re-sampled mid-run.
- scale_factor/function_mode change only on an accepted start and keep their value after the run until the next accepted start.
- Minimum cost per pair: 5 cycles (LOAD0, LOAD1, SEND0, SEND1, GAP) with in_valid held high.
- Counter compares as unsigned PW bits; cfg_pairs=2^PW-1 must complete without wrap.
- Simultaneous start and done: start is ignored, since the FSM is in FIN, not IDLE.

Test Plan:
- Reset, start with cfg_scale=0, cfg_mode=0, cfg_pairs=3, rows R0..R5 (lane k of Rn = n*256+k) with in_valid always 1 -> output sequence R0/a0, R1/a1, gap, R2/a0, R3/a1, gap, R4/a0, R5/a1, gap. Then done pulses exactly once, and exactly 6 idata_valid cycles occur.
- Same run with in_valid deasserted 3 cycles between R0 and R1 -> R0 and R1 still emitted on consecutive cycles; the gap after each pair is exactly 1 cycle; in_ready falls during SEND0..GAP.
- cfg_pairs=0 -> done pulses 2 cycles after start; idata_valid never asserts; in_ready stays 0.
- start with cfg_scale=2, cfg_mode=1, then pulse start again mid-run with cfg_scale=1 -> scale_factor=2 and function_mode=1 for the whole run; the second start is ignored; both values are still held after done.
- Assert rst_n=0 during SEND1 of pair 1 -> all outputs 0 asynchronously. After release, state is IDLE, busy=0, and no output until a new start.
- cfg_pairs=255 with continuous input -> 510 valid rows, done at cycle 1+255*5+1 after start, no counter wrap.
